// File: rtl/display_scan_if.sv
// Bundle between the display scan controller and the panel side: state
// select in, message select, digit counter and anode drives out.
interface display_scan_if;
  logic [7:0] estado;
  logic [7:0] msg_sel;
  logic       saida1Contador;
  logic       saida2Contador;
  logic [3:0] dig_n;
  logic       frame_done;
  logic       err;

  modport master (
    output estado,
    input  msg_sel,
    input  saida1Contador,
    input  saida2Contador,
    input  dig_n,
    input  frame_done,
    input  err
  );

  modport slave (
    input  estado,
    output msg_sel,
    output saida1Contador,
    output saida2Contador,
    output dig_n,
    output frame_done,
    output err
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with blanking and per-frame
// latching of the one-hot machine state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | anodes off, estado sampled each cycle until it is one-hot
//   ST_BLANK | anodes off at the start of a digit slot (ghosting guard)
//   ST_SHOW  | current digit anode driven low until the slot ends
module display_scan_controller #(
  parameter int unsigned DIV_MAX      = 3,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);

  localparam int unsigned PW = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_MAX);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    dig_q, dig_d;
  logic [7:0]    msg_sel_q, msg_sel_d;
  logic          err_q, err_d;
  logic          frame_done_q, frame_done_d;
  logic          estado_ok;
  logic [3:0]    dig_n;

  assign estado_ok = $onehot(bus.estado);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      dig_q        <= 2'd0;
      msg_sel_q    <= 8'h00;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dig_q        <= dig_d;
      msg_sel_q    <= msg_sel_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    dig_d        = dig_q;
    msg_sel_d    = msg_sel_q;
    err_d        = err_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        dig_d   = 2'd0;
        if (estado_ok) begin
          msg_sel_d = bus.estado;
          err_d     = 1'b0;
          state_d   = ST_BLANK;
        end else begin
          msg_sel_d = 8'h00;
          err_d     = 1'b1;
        end
      end

      ST_BLANK: begin
        presc_d = presc_q + PW'(1);
        if (presc_q == BLANK_LAST) state_d = ST_SHOW;
      end

      ST_SHOW: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          dig_d   = dig_q + 2'd1;
          state_d = ST_BLANK;
          // Frame boundary: the only point where a new estado is accepted.
          if (dig_q == 2'd3) begin
            frame_done_d = 1'b1;
            dig_d        = 2'd0;
            if (estado_ok) begin
              msg_sel_d = bus.estado;
            end else begin
              msg_sel_d = 8'h00;
              err_d     = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dig_n = 4'b1111;
    if (state_q == ST_SHOW) dig_n[dig_q] = 1'b0;
  end

  assign bus.msg_sel        = msg_sel_q;
  assign bus.err            = err_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.dig_n          = dig_n;
  assign bus.saida1Contador = dig_q[1];
  assign bus.saida2Contador = dig_q[0];

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter DIV_MAX, default 3, meaning the last prescaler count of one digit slot (slot = DIV_MAX+1 cycles).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1, meaning the number of anode-off cycles at the start of each slot; legal range 1..DIV_MAX.
REQ-003 SHALL have port clk input 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n input 1, the reset: synchronous, active-low.
REQ-005 SHALL have port estado input 8, the machine state one-hot in the order {VL,SN,SP,SR,S3,S2,S1,S0}, with bit0 = S0.
REQ-006 SHALL have port msg_sel output 8, the latched one-hot message select driven to the per-state display interfaces.
REQ-007 SHALL have port saida1Contador output 1, the digit index MSB.
REQ-008 SHALL have port saida2Contador output 1, the digit index LSB.
REQ-009 SHALL have port dig_n output 4, the active-low digit anodes; bit k lights digit k.
REQ-010 SHALL have port frame_done output 1, a one-cycle pulse at the end of the digit-3 slot.
REQ-011 SHALL have port err output 1, set while estado was last sampled as not one-hot.

Function
REQ-012 SHALL implement FSM states IDLE, BLANK and SHOW, plus a prescaler presc of width clog2(DIV_MAX+1) and a 2-bit digit counter dig.
REQ-013 SHALL drive saida1Contador = dig[1] and saida2Contador = dig[0] at all times.
REQ-014 IDLE SHALL behave as follows:
- dig_n=1111, presc=0, dig=0.
- Sample estado every cycle.
- If one-hot: next cycle msg_sel<=estado, err<=0, state BLANK.
- Else: msg_sel<=0, err<=1, stay in IDLE.
REQ-015 BLANK SHALL behave as follows:
- dig_n=1111, presc increments.
- When presc==BLANK_CYCLES-1: go to SHOW with presc incrementing.
REQ-016 SHOW SHALL drive dig_n with only bit dig low; presc increments.
REQ-017 When SHOW has presc==DIV_MAX, the block SHALL wrap presc to 0, increment dig modulo 4 and go to BLANK.
REQ-018 When the REQ-017 wrap occurs with dig==3, the block SHALL:
- Pulse frame_done in the next cycle.
- Resample estado at that wrap edge.
- If one-hot: msg_sel<=estado, continue in BLANK with dig=0.
- Else: msg_sel<=0, err<=1, dig<=0, go to IDLE.
REQ-019 estado changes between frame boundaries SHALL be ignored; msg_sel SHALL be stable for a whole frame of 4*(DIV_MAX+1) cycles.
REQ-020 Never more than one dig_n bit SHALL be low in any cycle.
REQ-021 No digit SHALL be lit in the first cycle after any dig change.
REQ-022 estado with zero bits set or with two or more bits set SHALL be treated as invalid.

Reset
REQ-023 With rst_n=0 at a clock edge, the next state SHALL be:
- state IDLE, presc=0, dig=0.
- msg_sel=0, dig_n=1111.
- frame_done=0, err=0.
REQ-024 Reset asserted mid-frame SHALL override all transitions, with no frame_done pulse.
REQ-025 After rst_n rises, the block SHALL resume at IDLE sampling.

Verification (DIV_MAX=3, BLANK_CYCLES=1)
REQ-026 Reset release with estado=8'h04 (S2) SHALL give:
- msg_sel=8'h04 one cycle later.
- Digit 0: 1 cycle dig_n=1111, then 3 cycles dig_n=1110.
- Digits 1..3 follow as 1101, 1011, 0111, each preceded by one blank cycle.
- frame_done pulses once every 16 cycles.
REQ-027 estado changes from 8'h04 to 8'h08 during digit 1 SHALL give:
- msg_sel held at 8'h04 until the digit-3 wrap.
- msg_sel=8'h08 from the next frame.
REQ-028 estado=8'h0C at the frame boundary SHALL give:
- err=1, msg_sel=0, dig_n=1111, IDLE.
- After restoring estado=8'h01: err=0 and msg_sel=8'h01 one cycle later.
REQ-029 estado=8'h00 out of reset SHALL hold the block in IDLE with err=1 and dig_n=1111 indefinitely.
REQ-030 rst_n=0 for one cycle during digit 2 SHALL give:
- All outputs at reset values next cycle.
- No frame_done pulse.
- Scan restarting at digit 0.
REQ-031 The bench SHALL check, every cycle of all scenarios:
- At most one dig_n bit low.
- {saida1Contador,saida2Contador} equals the index of the low dig_n bit whenever one is low.
